// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
//   Single-clock FIFO with valid/ready handshakes on both sides, a fill count,
//   programmable almost-full/almost-empty flags, sticky overflow/underflow
//   flags, a synchronous flush and a selectable read mode:
//     FWFT=1 : head word is shown combinationally on out_data while out_valid.
//     FWFT=0 : out_ready requests a read; out_data/out_valid follow one cycle
//              later, out_valid as a single-cycle pulse.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active low
//   in_valid      in   write request
//   in_ready      out  FIFO can accept a word (count != DEPTH)
//   in_data       in   write payload
//   out_valid     out  out_data holds a valid word
//   out_ready     in   FWFT: consumer takes head; standard: read request
//   out_data      out  read payload
//   count         out  words currently stored (0..DEPTH)
//   almost_full   out  count >= AFULL_LVL
//   almost_empty  out  count <= AEMPTY_LVL
//   overflow      out  sticky: write attempted while full
//   underflow     out  sticky: read attempted while empty
//   flush         in   synchronous clear of contents
//   clr_err       in   synchronous clear of overflow/underflow
// -----------------------------------------------------------------------------
module stream_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int FWFT       = 1,
   parameter int AFULL_LVL  = 12,
   parameter int AEMPTY_LVL = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic                      overflow,
   output logic                      underflow,
   input  logic                      flush,
   input  logic                      clr_err
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);

   localparam logic [ADDR_WIDTH:0] FULL_C   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LVL);
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LVL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  not_empty;
   logic                  push;
   logic                  pop;

   // Status decodes from the registered count only, so in_ready never
   // combinationally depends on out_ready (no write into a full FIFO even
   // when the head is being popped in the same cycle).
   assign not_empty    = (count != '0);
   assign in_ready     = (count != FULL_C);
   assign almost_full  = (count >= AFULL_C);
   assign almost_empty = (count <= AEMPTY_C);

   // In FWFT mode out_valid equals not_empty, so both modes reduce to the same
   // pop condition. Flush drops any push/pop of its cycle.
   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_ready & not_empty & ~flush;

   // NOTE: storage has no reset; only pointers/count define which entries are
   // live, so resetting the array would add reset fan-out for no benefit.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= in_data;
      end
   end

   // NOTE: non-blocking assignments in clocked blocks so every register sees
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags: a new event in the same cycle as clr_err wins.
   // Flush deliberately leaves them alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (in_valid & ~in_ready)   | (overflow  & ~clr_err);
         underflow <= (out_ready & ~not_empty) | (underflow & ~clr_err);
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign out_valid = not_empty;
         assign out_data  = mem[rd_ptr[ADDR_WIDTH-1:0]];
      end else begin : g_std
         logic                  out_valid_r;
         logic [DATA_WIDTH-1:0] out_data_r;

         // out_data_r keeps the last word read; flush only kills the pulse.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               out_valid_r <= 1'b0;
               out_data_r  <= '0;
            end else begin
               out_valid_r <= pop;
               if (pop) out_data_r <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
         end

         assign out_valid = out_valid_r;
         assign out_data  = out_data_r;
      end
   endgenerate

endmodule

// File: tb/tb_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_fifo
//   Directed bench for stream_fifo. One FWFT instance and one standard-mode
//   instance share clock and reset; expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_stream_fifo;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   // FWFT instance signals
   logic       f_in_valid = 1'b0, f_out_ready = 1'b0, f_flush = 1'b0, f_clr_err = 1'b0;
   logic [7:0] f_in_data = '0;
   logic       f_in_ready, f_out_valid, f_afull, f_aempty, f_ovf, f_unf;
   logic [7:0] f_out_data;
   logic [4:0] f_count;

   // standard-mode instance signals
   logic       s_in_valid = 1'b0, s_out_ready = 1'b0, s_flush = 1'b0, s_clr_err = 1'b0;
   logic [7:0] s_in_data = '0;
   logic       s_in_ready, s_out_valid, s_afull, s_aempty, s_ovf, s_unf;
   logic [7:0] s_out_data;
   logic [4:0] s_count;

   int total = 0;
   int bad   = 0;

   stream_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1), .AFULL_LVL(12), .AEMPTY_LVL(4)) u_fwft (
      .clk(clk), .rst(rst),
      .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
      .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data),
      .count(f_count), .almost_full(f_afull), .almost_empty(f_aempty),
      .overflow(f_ovf), .underflow(f_unf), .flush(f_flush), .clr_err(f_clr_err)
   );

   stream_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0), .AFULL_LVL(12), .AEMPTY_LVL(4)) u_std (
      .clk(clk), .rst(rst),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .count(s_count), .almost_full(s_afull), .almost_empty(s_aempty),
      .overflow(s_ovf), .underflow(s_unf), .flush(s_flush), .clr_err(s_clr_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sampling happens 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- reset state ----------------
      #2 rst = 1'b0;
      #2;
      check("rst_count",   f_count, 0);
      check("rst_in_ready", f_in_ready, 1);
      check("rst_aempty",  f_aempty, 1);
      check("rst_afull",   f_afull, 0);
      check("rst_out_valid", f_out_valid, 0);
      check("rst_ovf",     f_ovf, 0);
      check("rst_unf",     f_unf, 0);
      check("rst_std_data", s_out_data, 0);
      check("rst_std_valid", s_out_valid, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // ---------------- 4: standard-mode read latency ----------------
      s_in_valid = 1'b1; s_in_data = 8'hA5;
      tick();
      s_in_valid = 1'b0;
      tick();
      check("std_count_1", s_count, 1);
      check("std_idle_valid", s_out_valid, 0);
      s_out_ready = 1'b1;
      tick();
      s_out_ready = 1'b0;
      check("std_pulse_valid", s_out_valid, 1);
      check("std_pulse_data", s_out_data, 8'hA5);
      check("std_count_0", s_count, 0);
      tick();
      check("std_pulse_end", s_out_valid, 0);
      check("std_data_hold", s_out_data, 8'hA5);

      // ---------------- 1: fill to full, overflow ----------------
      for (int i = 0; i < 16; i++) begin
         f_in_valid = 1'b1; f_in_data = 8'(i);
         tick();
         check($sformatf("fill_count_%0d", i), f_count, i + 1);
         check($sformatf("fill_afull_%0d", i), f_afull, (i + 1 >= 12) ? 1 : 0);
      end
      check("full_in_ready", f_in_ready, 0);
      f_in_data = 8'hFF;
      tick();
      f_in_valid = 1'b0;
      check("ovf_set", f_ovf, 1);
      check("ovf_count", f_count, 16);
      check("ovf_head", f_out_data, 8'h00);

      // ---------------- 2: FWFT drain, underflow ----------------
      f_out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("drain_valid_%0d", i), f_out_valid, 1);
         check($sformatf("drain_data_%0d", i), f_out_data, i);
         check($sformatf("drain_aempty_%0d", i), f_aempty, (16 - i <= 4) ? 1 : 0);
         tick();
      end
      f_out_ready = 1'b0;
      check("drain_count", f_count, 0);
      check("drain_valid_end", f_out_valid, 0);
      check("drain_no_unf", f_unf, 0);
      f_out_ready = 1'b1;
      tick();
      f_out_ready = 1'b0;
      check("unf_set", f_unf, 1);
      // set event wins over clr_err; overflow is cleared
      f_clr_err = 1'b1; f_out_ready = 1'b1;
      tick();
      f_out_ready = 1'b0;
      check("clr_ovf", f_ovf, 0);
      check("unf_set_wins", f_unf, 1);
      tick();
      f_clr_err = 1'b0;
      check("clr_unf", f_unf, 0);

      // ---------------- 3: steady push+pop across pointer wrap ----------------
      for (int k = 0; k < 8; k++) begin
         f_in_valid = 1'b1; f_in_data = 8'(8'h10 + k);
         tick();
      end
      check("prefill_count", f_count, 8);
      f_out_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         f_in_data = 8'(8'h18 + k);
         check($sformatf("stream_data_%0d", k), f_out_data, 8'h10 + k);
         tick();
         check($sformatf("stream_count_%0d", k), f_count, 8);
      end
      f_in_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         check($sformatf("tail_data_%0d", j), f_out_data, 8'h38 + j);
         tick();
      end
      f_out_ready = 1'b0;
      check("tail_count", f_count, 0);
      check("tail_no_unf", f_unf, 0);

      // ---------------- 5: flush at count=5 with overflow pending ----------------
      f_in_valid = 1'b1;
      for (int k = 0; k < 17; k++) begin
         f_in_data = (k == 16) ? 8'hEE : 8'(8'h60 + k);
         tick();
      end
      f_in_valid = 1'b0;
      check("pre_flush_ovf", f_ovf, 1);
      f_out_ready = 1'b1;
      repeat (11) tick();
      f_out_ready = 1'b0;
      check("pre_flush_count", f_count, 5);
      check("pre_flush_head", f_out_data, 8'h6B);
      f_flush = 1'b1; f_in_valid = 1'b1; f_in_data = 8'h77; f_out_ready = 1'b1;
      tick();
      f_flush = 1'b0; f_in_valid = 1'b0; f_out_ready = 1'b0;
      check("flush_count", f_count, 0);
      check("flush_valid", f_out_valid, 0);
      check("flush_ovf_kept", f_ovf, 1);
      check("flush_in_ready", f_in_ready, 1);
      f_clr_err = 1'b1;
      tick();
      f_clr_err = 1'b0;
      check("flush_clr_ovf", f_ovf, 0);
      f_in_valid = 1'b1; f_in_data = 8'h42;
      tick();
      f_in_valid = 1'b0;
      check("post_flush_count", f_count, 1);
      check("post_flush_data", f_out_data, 8'h42);
      f_out_ready = 1'b1;
      tick();
      f_out_ready = 1'b0;

      // ---------------- 6: async reset mid-stream ----------------
      f_out_ready = 1'b1;
      tick();
      f_out_ready = 1'b0;
      check("pre_rst_unf", f_unf, 1);
      f_in_valid = 1'b1;
      for (int k = 0; k < 9; k++) begin
         f_in_data = 8'(8'h50 + k);
         tick();
      end
      f_in_valid = 1'b0;
      check("pre_rst_count", f_count, 9);
      #2 rst = 1'b0;
      #1;
      check("arst_count", f_count, 0);
      check("arst_valid", f_out_valid, 0);
      check("arst_unf", f_unf, 0);
      check("arst_ovf", f_ovf, 0);
      check("arst_aempty", f_aempty, 1);
      check("arst_in_ready", f_in_ready, 1);
      check("arst_std_data", s_out_data, 0);
      @(negedge clk);
      rst = 1'b1;
      f_in_valid = 1'b1; f_in_data = 8'h99;
      tick();
      f_in_valid = 1'b0;
      check("resume_count", f_count, 1);
      check("resume_valid", f_out_valid, 1);
      check("resume_data", f_out_data, 8'h99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
